imem_loader: RTL

- Writer side of the instruction memory: receives a program image over a byte-stream valid/ready link and writes it word-by-word into instruction memory through a write port.
- Holds the pipeline (`cpu_hold`) until a complete, checksum-verified image is loaded, then releases the core.
- Sits between the external host link and the instruction memory write port, beside the top-level pipeline.

---
 rtl/imem_loader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction memory. Receives a program image over a
//   byte-stream valid/ready link, writes it word-by-word into instruction
//   memory, and holds the core until the whole image has been loaded and its
//   checksum verified.
//
//   Frame: 4-byte little-endian word count N, N*4 little-endian payload
//   bytes, then one checksum byte equal to the XOR of all payload bytes.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   rx_valid    byte available on rx_data
//   rx_data     incoming byte
//   rx_ready    loader can accept a byte (HDR, DATA, CSUM)
//   start       one-cycle pulse, re-arms the loader from DONE or ERR
//   imem_we     instruction memory write enable, one-cycle pulse
//   imem_addr   word-aligned byte address of the write
//   imem_wdata  word to write
//   cpu_hold    high while the pipeline must stay held
//   done        image loaded and verified
//   error       header out of range or checksum mismatch
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  rx_ready,
   input  logic                  start,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [WIDTH-1:0]      imem_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error
);

   localparam int          IDX_W     = ADDR_WIDTH - 2;
   localparam logic [31:0] MAX_WORDS = 32'd1 << IDX_W;

   typedef enum logic [2:0] {
      HDR    = 3'd0,
      DATA   = 3'd1,
      CSUM   = 3'd2,
      DONE_S = 3'd3,
      ERR_S  = 3'd4
   } state_t;

   state_t           state;
   logic [1:0]       byte_cnt;
   logic [31:0]      shift_reg;    // shared by header and payload assembly
   logic [31:0]      word_count;
   logic [IDX_W-1:0] word_idx;
   logic [7:0]       csum;

   logic             accept;
   logic [31:0]      next_word;
   logic [31:0]      idx_plus1;

   assign accept    = rx_valid && rx_ready;
   // Bytes enter at the top and move down, so after four bytes the first
   // one received sits in [7:0] (little-endian).
   assign next_word = {rx_data, shift_reg[31:8]};
   // Index widened to 32 bits so the last-word test matches the full N.
   assign idx_plus1 = 32'(word_idx) + 32'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= HDR;
         byte_cnt   <= 2'd0;
         shift_reg  <= 32'd0;
         word_count <= 32'd0;
         word_idx   <= '0;
         csum       <= 8'd0;
         rx_ready   <= 1'b1;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            HDR: begin
               if (accept) begin
                  shift_reg <= next_word;
                  byte_cnt  <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     word_count <= next_word;
                     if (next_word == 32'd0) begin
                        state <= CSUM;
                     end else if (next_word > MAX_WORDS) begin
                        state    <= ERR_S;
                        rx_ready <= 1'b0;
                        error    <= 1'b1;
                     end else begin
                        state <= DATA;
                     end
                  end
               end
            end

            DATA: begin
               if (accept) begin
                  shift_reg <= next_word;
                  byte_cnt  <= byte_cnt + 2'd1;
                  csum      <= csum ^ rx_data;
                  if (byte_cnt == 2'd3) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= {word_idx, 2'b00};
                     imem_wdata <= next_word;
                     // Index stays at N-1 on the last word so it never
                     // needs more than IDX_W bits.
                     if (idx_plus1 == word_count) begin
                        state <= CSUM;
                     end else begin
                        word_idx <= word_idx + 1'b1;
                     end
                  end
               end
            end

            CSUM: begin
               if (accept) begin
                  rx_ready <= 1'b0;
                  if (rx_data == csum) begin
                     state    <= DONE_S;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state <= ERR_S;
                     error <= 1'b1;
                  end
               end
            end

            DONE_S, ERR_S: begin
               if (start) begin
                  state      <= HDR;
                  byte_cnt   <= 2'd0;
                  shift_reg  <= 32'd0;
                  word_count <= 32'd0;
                  word_idx   <= '0;
                  csum       <= 8'd0;
                  rx_ready   <= 1'b1;
                  cpu_hold   <= 1'b1;
                  done       <= 1'b0;
                  error      <= 1'b0;
               end
            end

            default: begin
               state <= HDR;
            end
         endcase
      end
   end

endmodule
